// File: rtl/selecionador_estoque_if.sv
// -----------------------------------------------------------------------------
// selecionador_estoque_if
// Bundle of every non-clock signal of the product selector.
//   master : keypad / payment / programming side (drives requests)
//   slave  : the selector itself (drives lookup results and pulses)
// Signals:
//   sel_valid/sel_ready, linha, coluna : selection handshake
//   rsp_valid, cod, valor, existe, disponivel : lookup result
//   confirma, cancela : payment side decision while rsp_valid is high
//   liberado, erro : one-cycle outcome pulses
//   prog_en, prog_addr, prog_price, prog_stock : run-time table write
//   vendas : completed-sale counter
// -----------------------------------------------------------------------------
interface selecionador_estoque_if #(
  parameter int ROW_W    = 2,
  parameter int COL_W    = 2,
  parameter int PRICE_W  = 3,
  parameter int STOCK_W  = 4,
  parameter int VENDAS_W = 8
);
  logic                     sel_valid;
  logic                     sel_ready;
  logic [ROW_W-1:0]         linha;
  logic [COL_W-1:0]         coluna;
  logic                     rsp_valid;
  logic [ROW_W+COL_W-1:0]   cod;
  logic [PRICE_W-1:0]       valor;
  logic                     existe;
  logic                     disponivel;
  logic                     confirma;
  logic                     cancela;
  logic                     liberado;
  logic                     erro;
  logic                     prog_en;
  logic [ROW_W+COL_W-1:0]   prog_addr;
  logic [PRICE_W-1:0]       prog_price;
  logic [STOCK_W-1:0]       prog_stock;
  logic [VENDAS_W-1:0]      vendas;

  modport master (
    output sel_valid, linha, coluna, confirma, cancela,
           prog_en, prog_addr, prog_price, prog_stock,
    input  sel_ready, rsp_valid, cod, valor, existe, disponivel,
           liberado, erro, vendas
  );

  modport slave (
    input  sel_valid, linha, coluna, confirma, cancela,
           prog_en, prog_addr, prog_price, prog_stock,
    output sel_ready, rsp_valid, cod, valor, existe, disponivel,
           liberado, erro, vendas
  );
endinterface

// File: rtl/selecionador_estoque.sv
// -----------------------------------------------------------------------------
// selecionador_estoque
// Vending-machine product selector with per-slot price and stock tables.
// A selection {linha, coluna} is accepted in IDLE, looked up for one cycle
// (LOOKUP) and presented in RESP until the payment side confirms, cancels,
// or the wait times out. A confirmed sale on an available slot decrements
// its stock, pulses liberado and bumps the sale counter; any other confirm
// or a timeout pulses erro.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset (restores catalogue and stock)
//   bus : selecionador_estoque_if.slave, all handshake/result/programming
// -----------------------------------------------------------------------------
module selecionador_estoque #(
  parameter int ROW_W      = 2,
  parameter int COL_W      = 2,
  parameter int PRICE_W    = 3,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 4,
  // Slot i price lives at bits [i*PRICE_W +: PRICE_W]; listed slot 15 first.
  parameter logic [(2**(ROW_W+COL_W))*PRICE_W-1:0] PRICE_INIT = {
    3'd5, 3'd4, 3'd3, 3'd1,   // slots 15..12
    3'd0, 3'd0, 3'd5, 3'd2,   // slots 11..8
    3'd0, 3'd0, 3'd1, 3'd6,   // slots 7..4
    3'd0, 3'd0, 3'd0, 3'd2    // slots 3..0
  },
  parameter int TIMEOUT    = 255,
  parameter int VENDAS_W   = 8
) (
  input logic                  clk,
  input logic                  rst,
  selecionador_estoque_if.slave bus
);

  localparam int AW = ROW_W + COL_W;
  localparam int N  = 2**AW;
  // Wait counter only needs to reach TIMEOUT; keep at least one bit.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state_q;
  logic [AW-1:0]         cod_q;
  logic [PRICE_W-1:0]    valor_q;
  logic                  existe_q;
  logic                  disponivel_q;
  logic                  rsp_valid_q;
  logic                  liberado_q;
  logic                  erro_q;
  logic [VENDAS_W-1:0]   vendas_q;
  logic [TW-1:0]         wait_q;

  // Slot tables: reset-initialised, so they live in registers.
  logic [PRICE_W-1:0]    price_q   [N];
  logic [STOCK_W-1:0]    stock_q   [N];
  logic [PRICE_W-1:0]    price_d   [N];
  logic [STOCK_W-1:0]    stock_d   [N];
  logic [PRICE_W-1:0]    price_rst [N];
  logic [STOCK_W-1:0]    stock_rst [N];

  logic                  sel_ready;
  logic                  sel_fire;
  logic                  prog_wr;
  logic                  sale_fire;
  logic                  timeout_hit;
  logic [PRICE_W-1:0]    lookup_price;
  logic [STOCK_W-1:0]    lookup_stock;

  // Programming owns the IDLE cycle, so a selection cannot be taken with it.
  assign sel_ready   = (state_q == IDLE) && !bus.prog_en;
  assign sel_fire    = sel_ready && bus.sel_valid;
  assign prog_wr     = (state_q == IDLE) && bus.prog_en;
  // cancela wins over confirma; disponivel_q guarantees stock is nonzero.
  assign sale_fire   = (state_q == RESP) && !bus.cancela && bus.confirma && disponivel_q;
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == TW'(TIMEOUT));

  assign lookup_price = price_q[cod_q];
  assign lookup_stock = stock_q[cod_q];

  // Per-slot reset values and next-state: programming and sale decrement
  // are mutually exclusive (IDLE vs RESP), so no arbitration is needed.
  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    assign price_rst[gi] = PRICE_INIT[gi*PRICE_W +: PRICE_W];
    assign stock_rst[gi] = (price_rst[gi] != '0) ? STOCK_W'(STOCK_INIT) : '0;

    always_comb begin
      price_d[gi] = price_q[gi];
      stock_d[gi] = stock_q[gi];
      if (prog_wr && (bus.prog_addr == AW'(gi))) begin
        price_d[gi] = bus.prog_price;
        stock_d[gi] = bus.prog_stock;
      end else if (sale_fire && (cod_q == AW'(gi))) begin
        stock_d[gi] = stock_q[gi] - STOCK_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      price_q <= price_rst;
      stock_q <= stock_rst;
    end else begin
      price_q <= price_d;
      stock_q <= stock_d;
    end
  end

  // Control FSM with registered result and pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cod_q        <= '0;
      valor_q      <= '0;
      existe_q     <= 1'b0;
      disponivel_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      liberado_q   <= 1'b0;
      erro_q       <= 1'b0;
      vendas_q     <= '0;
      wait_q       <= '0;
    end else begin
      liberado_q <= 1'b0;
      erro_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sel_fire) begin
            cod_q   <= {bus.linha, bus.coluna};
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          valor_q      <= lookup_price;
          existe_q     <= (lookup_price != '0);
          disponivel_q <= (lookup_price != '0) && (lookup_stock != '0);
          rsp_valid_q  <= 1'b1;
          wait_q       <= '0;
          state_q      <= RESP;
        end
        RESP: begin
          if (bus.cancela) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else if (bus.confirma) begin
            if (disponivel_q) begin
              liberado_q <= 1'b1;
              vendas_q   <= vendas_q + VENDAS_W'(1);
            end else begin
              erro_q <= 1'b1;
            end
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else if (timeout_hit) begin
            erro_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else begin
            wait_q <= wait_q + TW'(1);
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.sel_ready  = sel_ready;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.cod        = cod_q;
  assign bus.valor      = valor_q;
  assign bus.existe     = existe_q;
  assign bus.disponivel = disponivel_q;
  assign bus.liberado   = liberado_q;
  assign bus.erro       = erro_q;
  assign bus.vendas     = vendas_q;

endmodule

// File: tb/tb_selecionador_estoque.sv
// -----------------------------------------------------------------------------
// tb_selecionador_estoque
// Directed bench for selecionador_estoque (TIMEOUT overridden to 4).
// Expected lookup results are computed from a local catalogue/stock model,
// pushed to a queue when a selection is driven and popped when rsp_valid
// rises two cycles later.
// -----------------------------------------------------------------------------
module tb_selecionador_estoque;

  localparam int TMO = 4;

  typedef struct packed {
    logic [3:0] cod;
    logic [2:0] valor;
    logic       existe;
    logic       disp;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  selecionador_estoque_if #(.ROW_W(2), .COL_W(2), .PRICE_W(3), .STOCK_W(4), .VENDAS_W(8)) bus ();

  selecionador_estoque #(.TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [2:0] price_m [16];
  logic [3:0] stock_m [16];
  logic [7:0] vendas_m;
  rsp_t       exp_q [$];
  rsp_t       cur;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    logic [2:0] cat [16];
    cat = '{3'd2, 3'd0, 3'd0, 3'd0, 3'd6, 3'd1, 3'd0, 3'd0,
            3'd2, 3'd5, 3'd0, 3'd0, 3'd1, 3'd3, 3'd4, 3'd5};
    for (int i = 0; i < 16; i++) begin
      price_m[i] = cat[i];
      stock_m[i] = (cat[i] != 3'd0) ? 4'd4 : 4'd0;
    end
    vendas_m = 8'd0;
  endtask

  // Handshake, check 2-cycle latency, then pop and compare the response.
  task automatic sel(input int slot);
    rsp_t e;
    bus.sel_valid = 1'b1;
    bus.linha     = slot[3:2];
    bus.coluna    = slot[1:0];
    #1;
    check("sel_ready_idle", 32'(bus.sel_ready), 32'd1);
    e.cod    = slot[3:0];
    e.valor  = price_m[slot];
    e.existe = (price_m[slot] != 3'd0);
    e.disp   = e.existe && (stock_m[slot] != 4'd0);
    exp_q.push_back(e);
    step();
    bus.sel_valid = 1'b0;
    check("rsp_valid_lookup", 32'(bus.rsp_valid), 32'd0);
    step();
    check("rsp_valid_resp", 32'(bus.rsp_valid), 32'd1);
    cur = exp_q.pop_front();
    check($sformatf("cod_s%0d", slot),   32'(bus.cod),        32'(cur.cod));
    check($sformatf("valor_s%0d", slot), 32'(bus.valor),      32'(cur.valor));
    check($sformatf("existe_s%0d", slot),32'(bus.existe),     32'(cur.existe));
    check($sformatf("disp_s%0d", slot),  32'(bus.disponivel), 32'(cur.disp));
    $display("sel slot=%0d cod=%0d valor=%0d existe=%0b disp=%0b",
             slot, bus.cod, bus.valor, bus.existe, bus.disponivel);
  endtask

  task automatic respond(input logic c, input logic x);
    logic exp_lib, exp_err;
    bus.confirma = c;
    bus.cancela  = x;
    step();
    bus.confirma = 1'b0;
    bus.cancela  = 1'b0;
    exp_lib = !x && c && cur.disp;
    exp_err = !x && c && !cur.disp;
    if (exp_lib) begin
      stock_m[cur.cod] = stock_m[cur.cod] - 4'd1;
      vendas_m         = vendas_m + 8'd1;
    end
    check("liberado",       32'(bus.liberado),  32'(exp_lib));
    check("erro",           32'(bus.erro),      32'(exp_err));
    check("rsp_valid_done", 32'(bus.rsp_valid), 32'd0);
    check("sel_ready_done", 32'(bus.sel_ready), 32'd1);
    check("vendas",         32'(bus.vendas),    32'(vendas_m));
    check("stock_slot",     32'(dut.stock_q[cur.cod]), 32'(stock_m[cur.cod]));
    $display("rsp confirma=%0b cancela=%0b liberado=%0b erro=%0b vendas=%0d",
             c, x, bus.liberado, bus.erro, bus.vendas);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rsp_valid"},  32'(bus.rsp_valid),  32'd0);
    check({tag, "_cod"},        32'(bus.cod),        32'd0);
    check({tag, "_valor"},      32'(bus.valor),      32'd0);
    check({tag, "_existe"},     32'(bus.existe),     32'd0);
    check({tag, "_disp"},       32'(bus.disponivel), 32'd0);
    check({tag, "_liberado"},   32'(bus.liberado),   32'd0);
    check({tag, "_erro"},       32'(bus.erro),       32'd0);
    check({tag, "_vendas"},     32'(bus.vendas),     32'd0);
    check({tag, "_sel_ready"},  32'(bus.sel_ready),  32'd1);
  endtask

  initial begin
    int cnt;
    bus.sel_valid  = 1'b0;
    bus.linha      = '0;
    bus.coluna     = '0;
    bus.confirma   = 1'b0;
    bus.cancela    = 1'b0;
    bus.prog_en    = 1'b0;
    bus.prog_addr  = '0;
    bus.prog_price = '0;
    bus.prog_stock = '0;
    model_reset();

    step();
    step();
    rst = 1'b0;
    step();
    check_outputs_zero("reset");
    $display("reset released");

    // Plain sale of slot 0.
    sel(0);
    respond(1'b1, 1'b0);

    // Nonexistent slot 3: confirma yields erro.
    sel(3);
    respond(1'b1, 1'b0);

    // Drain slot 5, then one more attempt on the empty slot.
    for (int i = 0; i < 5; i++) begin
      sel(5);
      respond(1'b1, 1'b0);
    end

    // Program slot 3 while a selection is offered in the same cycle.
    bus.prog_en    = 1'b1;
    bus.prog_addr  = 4'd3;
    bus.prog_price = 3'd7;
    bus.prog_stock = 4'd2;
    bus.sel_valid  = 1'b1;
    bus.linha      = 2'd0;
    bus.coluna     = 2'd3;
    #1;
    check("sel_ready_prog", 32'(bus.sel_ready), 32'd0);
    step();
    bus.prog_en   = 1'b0;
    bus.sel_valid = 1'b0;
    price_m[3] = 3'd7;
    stock_m[3] = 4'd2;
    check("no_accept_during_prog", 32'(bus.rsp_valid), 32'd0);
    step();
    check("still_idle_after_prog", 32'(bus.rsp_valid), 32'd0);
    $display("prog slot=3 price=7 stock=2");
    sel(3);
    respond(1'b1, 1'b0);

    // confirma and cancela together: cancela wins.
    sel(0);
    respond(1'b1, 1'b1);

    // Cancel only.
    sel(4);
    respond(1'b0, 1'b1);

    // prog_en during RESP must be ignored.
    sel(14);
    bus.prog_en    = 1'b1;
    bus.prog_addr  = 4'd14;
    bus.prog_price = 3'd1;
    bus.prog_stock = 4'd9;
    step();
    bus.prog_en = 1'b0;
    respond(1'b1, 1'b0);
    sel(14);
    respond(1'b0, 1'b1);

    // Timeout with no response.
    sel(9);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      cnt++;
      if (bus.erro) break;
    end
    check("timeout_cycles", 32'(cnt), 32'(TMO + 1));
    check("timeout_no_lib", 32'(bus.liberado), 32'd0);
    check("timeout_rsp_low", 32'(bus.rsp_valid), 32'd0);
    check("timeout_stock", 32'(dut.stock_q[9]), 32'(stock_m[9]));
    $display("timeout after %0d cycles", cnt);

    // Reset while in RESP.
    sel(13);
    rst = 1'b1;
    step();
    check_outputs_zero("rst_resp");
    rst = 1'b0;
    model_reset();
    check("rst_stock0", 32'(dut.stock_q[0]), 32'd4);
    check("rst_stock5", 32'(dut.stock_q[5]), 32'd4);
    $display("reset during RESP");
    sel(3);
    respond(1'b1, 1'b0);
    sel(5);
    respond(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
